// File: rtl/acquire_beat_narrower.sv
// Acquire beat narrower: splits 64-bit arbiter beats into 32-bit half-beats.
// One-entry registered buffer; header and grant index pass through unchanged.
module acquire_beat_narrower #(
  parameter int IN_DATA_W = 64,
  parameter int IN_BEAT_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_chosen,
  input  logic [1:0]             in_header_src,
  input  logic [1:0]             in_header_dst,
  input  logic [25:0]            in_addr_block,
  input  logic                   in_client_xact_id,
  input  logic [IN_BEAT_W-1:0]   in_addr_beat,
  input  logic                   in_is_builtin_type,
  input  logic [2:0]             in_a_type,
  input  logic [11:0]            in_union,
  input  logic [IN_DATA_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_chosen,
  output logic [1:0]             out_header_src,
  output logic [1:0]             out_header_dst,
  output logic [25:0]            out_addr_block,
  output logic                   out_client_xact_id,
  output logic [IN_BEAT_W:0]     out_addr_beat,
  output logic                   out_is_builtin_type,
  output logic [2:0]             out_a_type,
  output logic [11:0]            out_union,
  output logic [IN_DATA_W/2-1:0] out_data,
  output logic                   out_last
);

  localparam int OW = IN_DATA_W / 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]           chosen;
    logic [1:0]           src;
    logic [1:0]           dst;
    logic [25:0]          addr_block;
    logic                 xact_id;
    logic [IN_BEAT_W-1:0] addr_beat;
    logic                 builtin;
    logic [2:0]           a_type;
    logic [11:0]          union_f;
    logic [IN_DATA_W-1:0] data;
    logic                 has_data;
  } buf_t;

  state_t state;
  buf_t   b;

  logic in_has_data;
  logic out_fire;
  logic final_half;
  logic accept;
  logic is_hi;
  logic is_put_block;

  assign in_has_data = in_is_builtin_type &
                       ((in_a_type == 3'd2) |
                        (in_a_type == 3'd3) |
                        (in_a_type == 3'd4));

  assign out_valid  = (state != EMPTY);
  assign out_fire   = out_valid & out_ready;
  assign final_half = (state == SEND_HI) |
                      ((state == SEND_LO) & ~b.has_data);
  assign in_ready   = (state == EMPTY) | (out_fire & final_half);
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) state <= SEND_LO;
        end
        SEND_LO: begin
          if (out_fire) begin
            if (b.has_data) state <= SEND_HI;
            else            state <= accept ? SEND_LO : EMPTY;
          end
        end
        SEND_HI: begin
          if (out_fire) state <= accept ? SEND_LO : EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Payload is never reset; state alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      b.chosen     <= in_chosen;
      b.src        <= in_header_src;
      b.dst        <= in_header_dst;
      b.addr_block <= in_addr_block;
      b.xact_id    <= in_client_xact_id;
      b.addr_beat  <= in_addr_beat;
      b.builtin    <= in_is_builtin_type;
      b.a_type     <= in_a_type;
      b.union_f    <= in_union;
      b.data       <= in_data;
      b.has_data   <= in_has_data;
    end
  end

  assign is_hi        = (state == SEND_HI);
  assign is_put_block = b.builtin & (b.a_type == 3'd3);

  assign out_chosen          = b.chosen;
  assign out_header_src      = b.src;
  assign out_header_dst      = b.dst;
  assign out_addr_block      = b.addr_block;
  assign out_client_xact_id  = b.xact_id;
  assign out_is_builtin_type = b.builtin;
  assign out_a_type          = b.a_type;
  assign out_union           = b.union_f;
  assign out_addr_beat       = {b.addr_beat, is_hi};

  always_comb begin
    out_data = '0;
    if (b.has_data)
      out_data = is_hi ? b.data[IN_DATA_W-1:OW] : b.data[OW-1:0];
  end

  // PutBlock ends only on its last beat's upper half.
  always_comb begin
    out_last = 1'b0;
    if (state == SEND_HI)
      out_last = is_put_block ? (b.addr_beat == '1) : 1'b1;
    else if (state == SEND_LO)
      out_last = ~b.has_data;
  end

endmodule

// File: tb/tb_acquire_beat_narrower.sv
// Directed bench for acquire_beat_narrower.
// Inputs change at posedge+1, outputs are checked at posedge+4.
module tb_acquire_beat_narrower;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_chosen;
  logic [1:0]  in_header_src;
  logic [1:0]  in_header_dst;
  logic [25:0] in_addr_block;
  logic        in_client_xact_id;
  logic [2:0]  in_addr_beat;
  logic        in_is_builtin_type;
  logic [2:0]  in_a_type;
  logic [11:0] in_union;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chosen;
  logic [1:0]  out_header_src;
  logic [1:0]  out_header_dst;
  logic [25:0] out_addr_block;
  logic        out_client_xact_id;
  logic [3:0]  out_addr_beat;
  logic        out_is_builtin_type;
  logic [2:0]  out_a_type;
  logic [11:0] out_union;
  logic [31:0] out_data;
  logic        out_last;

  int n_chk;
  int n_err;
  int nacc;
  logic acc;

  acquire_beat_narrower dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_chosen           (in_chosen),
    .in_header_src       (in_header_src),
    .in_header_dst       (in_header_dst),
    .in_addr_block       (in_addr_block),
    .in_client_xact_id   (in_client_xact_id),
    .in_addr_beat        (in_addr_beat),
    .in_is_builtin_type  (in_is_builtin_type),
    .in_a_type           (in_a_type),
    .in_union            (in_union),
    .in_data             (in_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_chosen          (out_chosen),
    .out_header_src      (out_header_src),
    .out_header_dst      (out_header_dst),
    .out_addr_block      (out_addr_block),
    .out_client_xact_id  (out_client_xact_id),
    .out_addr_beat       (out_addr_beat),
    .out_is_builtin_type (out_is_builtin_type),
    .out_a_type          (out_a_type),
    .out_union           (out_union),
    .out_data            (out_data),
    .out_last            (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input logic [1:0] ch,
                          input logic bi,
                          input logic [2:0] at,
                          input logic [2:0] bt,
                          input logic [63:0] d);
    in_valid           = 1'b1;
    in_chosen          = ch;
    in_header_src      = 2'd1;
    in_header_dst      = 2'd2;
    in_addr_block      = 26'h1234567;
    in_client_xact_id  = 1'b1;
    in_is_builtin_type = bi;
    in_a_type          = at;
    in_addr_beat       = bt;
    in_union           = 12'habc;
    in_data            = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pb_data(input int k);
    return {32'ha0000000 | k, 32'hb0000000 | k};
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    out_ready = 1'b1;
    set_beat(2'd0, 1'b0, 3'd0, 3'd0, 64'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #20;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    step();
    reset = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1);

    // Single Put
    step();
    set_beat(2'd1, 1'b1, 3'd2, 3'd5, 64'h1122334455667788);
    #3 check("put_rdy0", in_ready, 1);
    step();
    in_valid = 1'b0;
    #3;
    check("put_lo_valid", out_valid, 1);
    check("put_lo_beat", out_addr_beat, 10);
    check("put_lo_data", out_data, 64'h55667788);
    check("put_lo_last", out_last, 0);
    check("put_lo_rdy", in_ready, 0);
    check("put_src", out_header_src, 1);
    check("put_dst", out_header_dst, 2);
    check("put_blk", out_addr_block, 26'h1234567);
    check("put_union", out_union, 12'habc);
    check("put_xid", out_client_xact_id, 1);
    check("put_type", out_a_type, 2);
    check("put_chosen", out_chosen, 1);
    step();
    #3;
    check("put_hi_beat", out_addr_beat, 11);
    check("put_hi_data", out_data, 64'h11223344);
    check("put_hi_last", out_last, 1);
    check("put_hi_rdy", in_ready, 1);
    step();
    #3 check("put_empty", out_valid, 0);

    // PutBlock, 8 beats back to back from port 2
    step();
    nacc = 0;
    set_beat(2'd2, 1'b1, 3'd3, 3'd0, pb_data(0));
    #3 check("pb_rdy0", in_ready, 1);
    acc = in_valid & in_ready;
    for (int i = 0; i < 16; i++) begin
      step();
      if (acc) begin
        nacc++;
        if (nacc < 8)
          set_beat(2'd2, 1'b1, 3'd3, 3'(nacc), pb_data(nacc));
        else
          in_valid = 1'b0;
      end
      #3;
      check($sformatf("pb_valid%0d", i), out_valid, 1);
      check($sformatf("pb_beat%0d", i), out_addr_beat, i);
      check($sformatf("pb_chosen%0d", i), out_chosen, 2);
      check($sformatf("pb_last%0d", i), out_last, i == 15);
      check($sformatf("pb_rdy%0d", i), in_ready, i % 2);
      if (i % 2 == 1)
        check($sformatf("pb_data%0d", i), out_data, pb_data(i / 2) >> 32);
      else
        check($sformatf("pb_data%0d", i), out_data,
              pb_data(i / 2) & 64'hffffffff);
      acc = in_valid & in_ready;
    end
    check("pb_naccept", nacc, 8);
    step();
    #3 check("pb_empty", out_valid, 0);

    // GetBlock streamed, one output per cycle
    step();
    nacc = 0;
    set_beat(2'd3, 1'b1, 3'd1, 3'd0, 64'hdeadbeefcafef00d);
    #3;
    acc = in_valid & in_ready;
    for (int i = 0; i < 4; i++) begin
      step();
      if (acc) begin
        nacc++;
        if (nacc < 4)
          set_beat(2'd3, 1'b1, 3'd1, 3'(nacc), 64'hdeadbeefcafef00d);
        else
          in_valid = 1'b0;
      end
      #3;
      check($sformatf("gb_valid%0d", i), out_valid, 1);
      check($sformatf("gb_beat%0d", i), out_addr_beat, 2 * i);
      check($sformatf("gb_data%0d", i), out_data, 0);
      check($sformatf("gb_last%0d", i), out_last, 1);
      check($sformatf("gb_rdy%0d", i), in_ready, 1);
      acc = in_valid & in_ready;
    end
    step();
    #3 check("gb_empty", out_valid, 0);

    // Backpressure in SEND_HI with a waiting beat
    step();
    set_beat(2'd1, 1'b1, 3'd4, 3'd2, 64'h0123456789abcdef);
    step();
    in_valid = 1'b0;
    #3 check("bp_lo_beat", out_addr_beat, 4);
    step();
    out_ready = 1'b0;
    set_beat(2'd0, 1'b1, 3'd0, 3'd3, 64'hffff0000ffff0000);
    for (int k = 0; k < 5; k++) begin
      #3;
      check($sformatf("bp_valid%0d", k), out_valid, 1);
      check($sformatf("bp_beat%0d", k), out_addr_beat, 5);
      check($sformatf("bp_data%0d", k), out_data, 64'h01234567);
      check($sformatf("bp_last%0d", k), out_last, 1);
      check($sformatf("bp_chosen%0d", k), out_chosen, 1);
      check($sformatf("bp_rdy%0d", k), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #3;
    check("bp_rel_rdy", in_ready, 1);
    check("bp_rel_beat", out_addr_beat, 5);
    step();
    in_valid = 1'b0;
    #3;
    check("bp_new_valid", out_valid, 1);
    check("bp_new_beat", out_addr_beat, 6);
    check("bp_new_data", out_data, 0);
    check("bp_new_last", out_last, 1);
    check("bp_new_chosen", out_chosen, 0);
    step();
    #3 check("bp_empty", out_valid, 0);

    // Asynchronous reset during SEND_LO of a PutBlock
    step();
    set_beat(2'd2, 1'b1, 3'd3, 3'd0, pb_data(9));
    step();
    in_valid = 1'b0;
    #3 check("ar_pre_valid", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_last", out_last, 0);
    step();
    reset = 1'b1;
    #3;
    check("ar_rdy", in_ready, 1);
    check("ar_post_valid", out_valid, 0);
    step();
    #3 check("ar_still_empty", out_valid, 0);

    // Non-builtin a_type 3 is a non-data message
    step();
    set_beat(2'd1, 1'b0, 3'd3, 3'd4, 64'h5555aaaa5555aaaa);
    step();
    in_valid = 1'b0;
    #3;
    check("nb_valid", out_valid, 1);
    check("nb_beat", out_addr_beat, 8);
    check("nb_data", out_data, 0);
    check("nb_last", out_last, 1);
    check("nb_rdy", in_ready, 1);
    step();
    #3 check("nb_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
